regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Round-robin arbiter that shares one single-ported 32-entry register memory between several requesters (instruction-fetch datapath, debug/host loader, etc.). Each requester issues read or write transactions over a valid/ready handshake; the block grants at most one per cycle, drives the memory port, and returns read data one cycle later. An optional lock mechanism gives one requester exclusive ownership for atomic read-modify-write sequences.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_W, 32, memory word width
- ADDR_W, 5, memory address width (32 entries)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester transaction valid
- req_ready  output  NUM_REQ  per-requester grant; transfer when valid & ready
- req_write  input  NUM_REQ  1 = write, 0 = read
- req_lock  input  NUM_REQ  request/hold exclusive ownership (lock build only)
- req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_REQ*DATA_W  packed write data, same packing
- rsp_valid  output  NUM_REQ  one-cycle pulse: read data for requester i on rsp_rdata
- rsp_rdata  output  DATA_W  read data
- mem_en  output  1  memory access this cycle
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en & !mem_we

## Operation
- Registered state: rr_ptr (round-robin pointer, $clog2(NUM_REQ) bits), lock state (ARB/LOCKED), lock owner index, response pipeline (rsp_pend, rsp_idx).
- Arbitration (ARB): scan requesters starting at rr_ptr, wrapping modulo NUM_REQ; first with req_valid=1 is granted. Exactly one req_ready bit high when any valid; all low otherwise.
- After a grant to i: rr_ptr <= (i+1) mod NUM_REQ. No grant -> rr_ptr unchanged.
- Grant cycle drives mem_en=1, mem_we=req_write[i], mem_addr/mem_wdata from requester i's slice.
- Read grant: next cycle rsp_valid[i]=1, rsp_rdata=mem_rdata. Write grant: no response.
- rsp_rdata = 0 when no rsp_valid bit set. Requesters must accept responses unconditionally (no response backpressure).
- Back-to-back grants allowed every cycle; reads and writes freely interleaved. Read of an address written the previous cycle returns the new data (memory property; arbiter adds no forwarding).
- Lock FSM (lock build): ARB -> LOCKED when a granted transaction has req_lock=1; owner <= i. In LOCKED only owner is eligible; others see req_ready=0 even if valid. Owner valid low -> idle cycle, stay LOCKED. LOCKED -> ARB when owner's granted transaction has req_lock=0 (that transaction completes normally). rr_ptr updates on every grant in both states.
- Reset (any time): rr_ptr=0, state ARB, rsp_pend=0; in-flight read response is dropped.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. While reset is high all outputs forced to these values.
- req_ready and mem_* are combinational from req_* and registered state (same-cycle grant, zero added latency).
- Read latency: grant at edge T -> rsp_valid at cycle T+1, one cycle wide.
- Throughput: one transaction per cycle total; with all NUM_REQ continuously valid, each granted exactly once per NUM_REQ cycles.
- req_valid deasserted without ready: legal, nothing issued; arbiter keeps no memory of it.

## Configuration
- REGFILE_ARB_LOCK_EN defined: lock FSM and owner register present as described.
- Not defined: req_lock ignored, state permanently ARB, pure round-robin; port list unchanged.

## Test plan
- Reset then req 0 read addr 5 (mem[5]=0x0000abcd) -> req_ready=01 same cycle, next cycle rsp_valid=01, rsp_rdata=0x0000abcd.
- Both valid continuously, reads -> grants alternate 0,1,0,1; rr_ptr wraps; rsp_valid follows grants one cycle later.
- Req 1 writes 0xdeadbeef to addr 3, next cycle req 0 reads addr 3 -> rsp_rdata=0xdeadbeef, rsp_valid=01.
- Lock build: req 0 read with lock=1, req 1 valid throughout -> req 1 starved; req 0 write with lock=0 -> next cycle req 1 granted.
- Reset asserted the cycle after a read grant -> rsp_valid stays 0, all outputs 0, first grant after release goes to requester 0.
- No-lock build: req_lock=1 on req 0 with req 1 valid -> normal alternation 0,1,0,1.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one single-ported register memory among NUM_REQ requesters.
// Optional lock feature: define REGFILE_ARB_LOCK_EN for exclusive ownership during read-modify-write.
module regfile_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arbStateT;

  logic [ADDR_W-1:0]  reqAddrArr  [NUM_REQ];
  logic [DATA_W-1:0]  reqWdataArr [NUM_REQ];

  logic [PTR_W-1:0]   rrPtr;
  logic [PTR_W-1:0]   rrPtrNext;
  logic [PTR_W-1:0]   grantIdx;
  logic [PTR_W-1:0]   scanPtr;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grantVec;
  logic               anyGrant;

  logic               rspPend;
  logic [PTR_W-1:0]   rspIdx;

  arbStateT           state;
  logic [PTR_W-1:0]   lockOwner;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : gUnpack
      assign reqAddrArr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign reqWdataArr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // While locked only the owner may compete; everyone else is masked off.
  assign eligible = (state == LOCKED) ? (req_valid & (NUM_REQ'(1) << lockOwner)) : req_valid;

  always_comb begin
    anyGrant = 1'b0;
    grantIdx = '0;
    scanPtr  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scanPtr = PTR_W'((int'(rrPtr) + k) % NUM_REQ);
      if (!anyGrant && eligible[scanPtr]) begin
        anyGrant = 1'b1;
        grantIdx = scanPtr;
      end
    end
  end

  assign grantVec = anyGrant ? (NUM_REQ'(1) << grantIdx) : '0;

  always_comb begin
    rrPtrNext = rrPtr;
    if (anyGrant) begin
      rrPtrNext = (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + PTR_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rrPtr   <= '0;
      rspPend <= 1'b0;
      rspIdx  <= '0;
    end else begin
      rrPtr   <= rrPtrNext;
      rspPend <= anyGrant && !req_write[grantIdx];
      rspIdx  <= grantIdx;
    end
  end

`ifdef REGFILE_ARB_LOCK_EN
  arbStateT         stateNext;
  logic [PTR_W-1:0] lockOwnerNext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ARB;
      lockOwner <= '0;
    end else begin
      state     <= stateNext;
      lockOwner <= lockOwnerNext;
    end
  end

  // The releasing transaction (lock=0 from the owner) still completes normally.
  always_comb begin
    stateNext     = state;
    lockOwnerNext = lockOwner;
    if (anyGrant) begin
      case (state)
        ARB: begin
          if (req_lock[grantIdx]) begin
            stateNext     = LOCKED;
            lockOwnerNext = grantIdx;
          end
        end
        LOCKED: begin
          if (!req_lock[grantIdx]) begin
            stateNext = ARB;
          end
        end
        default: stateNext = ARB;
      endcase
    end
  end
`else
  logic unusedLock;

  assign state      = ARB;
  assign lockOwner  = '0;
  assign unusedLock = ^req_lock;
`endif

  always_comb begin
    req_ready = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    if (!reset) begin
      req_ready = grantVec;
      if (anyGrant) begin
        mem_en    = 1'b1;
        mem_we    = req_write[grantIdx];
        mem_addr  = reqAddrArr[grantIdx];
        mem_wdata = reqWdataArr[grantIdx];
      end
      if (rspPend) begin
        rsp_valid = NUM_REQ'(1) << rspIdx;
        rsp_rdata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: behavioural register memory, read-response scoreboard,
// hand-derived grant sequence; lock scenarios selected by REGFILE_ARB_LOCK_EN.
module tb_regfile_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write = '0;
  logic [NUM_REQ-1:0]        req_lock = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          due;
  } rspEntryT;

  rspEntryT    sbQ[$];
  logic [31:0] ram    [32];
  logic [31:0] expMem [32];
  int          assertCount = 0;
  int          failCount   = 0;
  int          cycleNum    = 0;

  regfile_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_lock (req_lock),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] initWord(input int i);
    if (i == 5) return 32'h0000abcd;
    return 32'h10000000 + 32'(i * 17);
  endfunction

  // Single-ported memory with one cycle of read latency.
  always @(posedge clock) begin
    cycleNum <= cycleNum + 1;
    if (cycleNum == 0) begin
      for (int i = 0; i < 32; i++) ram[i] <= initWord(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycleNum);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkVal({tag, "_ready"},     64'(req_ready), 64'd0);
    checkVal({tag, "_mem_en"},    64'(mem_en),    64'd0);
    checkVal({tag, "_mem_we"},    64'(mem_we),    64'd0);
    checkVal({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    checkVal({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    checkVal({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    checkVal({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
  endtask

  // Drives one cycle of requests, checks grant/memory port and any due response.
  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [1:0] l,
                       input int a0, input int a1,
                       input logic [31:0] d0, input logic [31:0] d1, input int expGrant);
    rspEntryT    e;
    int          gAddr;
    logic [31:0] gData;
    req_valid = v;
    req_write = w;
    req_lock  = l;
    req_addr  = {5'(a1), 5'(a0)};
    req_wdata = {d1, d0};
    @(negedge clock);
    if (sbQ.size() > 0 && sbQ[0].due == cycleNum) begin
      e = sbQ.pop_front();
      checkVal("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
      checkVal("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
    end else begin
      checkVal("rsp_valid_quiet", 64'(rsp_valid), 64'd0);
      checkVal("rsp_rdata_quiet", 64'(rsp_rdata), 64'd0);
    end
    if (expGrant < 0) begin
      checkVal("req_ready_none", 64'(req_ready), 64'd0);
      checkVal("mem_en_none",    64'(mem_en),    64'd0);
    end else begin
      gAddr = (expGrant == 1) ? a1 : a0;
      gData = (expGrant == 1) ? d1 : d0;
      checkVal("req_ready", 64'(req_ready), 64'(1) << expGrant);
      checkVal("mem_en",    64'(mem_en),    64'd1);
      checkVal("mem_we",    64'(mem_we),    64'(w[expGrant]));
      checkVal("mem_addr",  64'(mem_addr),  64'(5'(gAddr)));
      checkVal("mem_wdata", 64'(mem_wdata), 64'(gData));
      if (w[expGrant]) begin
        expMem[5'(gAddr)] = gData;
      end else begin
        e.idx  = expGrant;
        e.data = expMem[5'(gAddr)];
        e.due  = cycleNum + 1;
        sbQ.push_back(e);
      end
    end
    $display("txn cycle %0d: valid=%b write=%b lock=%b ready=%b mem_en=%b addr=%0d rsp_valid=%b rdata=0x%08h",
             cycleNum, v, w, l, req_ready, mem_en, mem_addr, rsp_valid, rsp_rdata);
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) expMem[i] = initWord(i);

    // Outputs held at reset values while reset is high, even with requests pending.
    @(posedge clock);
    #1;
    req_valid = 2'b11;
    req_write = 2'b10;
    req_addr  = {5'd9, 5'd4};
    req_wdata = {32'h12345678, 32'h9abcdef0};
    @(negedge clock);
    checkIdleOutputs("reset");
    $display("txn cycle %0d: reset held, outputs idle", cycleNum);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single read from requester 0.
    drive(2'b01, 2'b00, 2'b00, 5, 0, 32'h0, 32'h0, 0);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, -1);

    // Both continuously valid: strict alternation (pointer now at 1).
    drive(2'b11, 2'b00, 2'b00, 1, 2, 32'h0, 32'h0, 1);
    drive(2'b11, 2'b00, 2'b00, 1, 2, 32'h0, 32'h0, 0);
    drive(2'b11, 2'b00, 2'b00, 6, 7, 32'h0, 32'h0, 1);
    drive(2'b11, 2'b00, 2'b00, 6, 7, 32'h0, 32'h0, 0);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, -1);

    // Write then immediate read-back of the same address.
    drive(2'b10, 2'b10, 2'b00, 0, 3, 32'h0, 32'hdeadbeef, 1);
    drive(2'b01, 2'b00, 2'b00, 3, 0, 32'h0, 32'h0, 0);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, -1);

`ifdef REGFILE_ARB_LOCK_EN
    // Requester 0 takes the lock, requester 1 is starved until the unlocking write.
    drive(2'b01, 2'b00, 2'b01, 7, 0, 32'h0, 32'h0, 0);
    drive(2'b10, 2'b00, 2'b00, 0, 6, 32'h0, 32'h0, -1);
    drive(2'b11, 2'b00, 2'b01, 8, 6, 32'h0, 32'h0, 0);
    drive(2'b11, 2'b01, 2'b00, 9, 6, 32'h00000055, 32'h0, 0);
    drive(2'b11, 2'b00, 2'b00, 9, 6, 32'h0, 32'h0, 1);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, -1);
`else
    // Lock request ignored: plain alternation.
    drive(2'b11, 2'b00, 2'b01, 10, 11, 32'h0, 32'h0, 1);
    drive(2'b11, 2'b00, 2'b01, 10, 11, 32'h0, 32'h0, 0);
    drive(2'b11, 2'b00, 2'b01, 12, 13, 32'h0, 32'h0, 1);
    drive(2'b11, 2'b00, 2'b01, 12, 13, 32'h0, 32'h0, 0);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, -1);
`endif

    // Reset right after a read grant: response dropped, pointer back to 0.
    drive(2'b10, 2'b00, 2'b00, 0, 4, 32'h0, 32'h0, 1);
    reset = 1'b1;
    sbQ.delete();
    req_valid = 2'b11;
    req_write = 2'b00;
    req_lock  = 2'b00;
    @(negedge clock);
    checkIdleOutputs("midreset");
    $display("txn cycle %0d: reset during pending read, outputs idle", cycleNum);
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 12, 13, 32'h0, 32'h0, 0);
    drive(2'b11, 2'b00, 2'b00, 3, 9, 32'h0, 32'h0, 1);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, -1);

    checkVal("scoreboard_drained", 64'(sbQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
